// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: initiator side of the 16-bit ALU interface.
// Accepts one command at a time, drives the combinational ALU for a per-op latency,
// registers result/cc, hands them back over a valid/ready response port and keeps an
// architectural {N,Z,C,V} flags register for branch-condition evaluation.
// Optional feature: define STICKY_OVF_EN to make flags_q[0] (V) sticky until ovf_clr/reset.
module alu_cmd_sequencer #(
    parameter int unsigned BASE_LAT = 1,
    parameter int unsigned MUL_LAT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    // command port
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    // response port
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [3:0]  rsp_cc,
    output logic        rsp_err,
    // ALU side
    output logic [15:0] alu_valA,
    output logic [15:0] alu_valB,
    output logic [3:0]  alu_aluop,
    output logic        alu_sub,
    input  logic [15:0] alu_result,
    input  logic [3:0]  alu_cc,
    // flags / branch condition
    output logic [3:0]  flags_q,
    input  logic [2:0]  cond_sel,
    output logic        cond_true,
    input  logic        ovf_clr
);

    localparam int unsigned MaxLat = (MUL_LAT > BASE_LAT) ? MUL_LAT : BASE_LAT;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    localparam logic [3:0] OpAdd  = 4'b0001;
    localparam logic [3:0] OpSub  = 4'b0010;
    localparam logic [3:0] OpShl  = 4'b0101;
    localparam logic [3:0] OpShar = 4'b0110;
    localparam logic [3:0] OpShlr = 4'b0111;
    localparam logic [3:0] OpRl   = 4'b1000;
    localparam logic [3:0] OpRr   = 4'b1001;
    localparam logic [3:0] OpAnd  = 4'b1011;
    localparam logic [3:0] OpOr   = 4'b1100;
    localparam logic [3:0] OpXor  = 4'b1101;
    localparam logic [3:0] OpNot  = 4'b1110;
    localparam logic [3:0] OpMul  = 4'b1111;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StResp = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [15:0]       a_q, a_d;
    logic [15:0]       b_q, b_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [15:0]       rsp_result_q, rsp_result_d;
    logic [3:0]        rsp_cc_q, rsp_cc_d;
    logic              rsp_err_q, rsp_err_d;
    logic [3:0]        flags_d;
    logic              req_legal;

    // Opcode legality decode; the four unused encodings bypass the ALU entirely.
    always_comb begin
        req_legal = 1'b0;
        unique case (req_op)
            OpAdd, OpSub, OpShl, OpShar, OpShlr, OpRl, OpRr,
            OpAnd, OpOr, OpXor, OpNot, OpMul: req_legal = 1'b1;
            default:                          req_legal = 1'b0;
        endcase
    end

    // State register and datapath flops; synchronous reset drops any in-flight op.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            op_q         <= 4'b0000;
            a_q          <= 16'h0000;
            b_q          <= 16'h0000;
            cnt_q        <= '0;
            rsp_result_q <= 16'h0000;
            rsp_cc_q     <= 4'b0000;
            rsp_err_q    <= 1'b0;
            flags_q      <= 4'b0000;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cnt_q        <= cnt_d;
            rsp_result_q <= rsp_result_d;
            rsp_cc_q     <= rsp_cc_d;
            rsp_err_q    <= rsp_err_d;
            flags_q      <= flags_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in EXEC, capture on the last EXEC cycle.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        cnt_d        = cnt_q;
        rsp_result_d = rsp_result_q;
        rsp_cc_d     = rsp_cc_q;
        rsp_err_d    = rsp_err_q;
        flags_d      = flags_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d = req_op;
                    a_d  = req_a;
                    b_d  = req_b;
                    if (req_legal) begin
                        cnt_d   = (req_op == OpMul) ? CntW'(MUL_LAT) : CntW'(BASE_LAT);
                        state_d = StExec;
                    end else begin
                        // Illegal op answers immediately with an error and zero payload.
                        rsp_result_d = 16'h0000;
                        rsp_cc_d     = 4'b0000;
                        rsp_err_d    = 1'b1;
                        state_d      = StResp;
                    end
                end
            end
            StExec: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    rsp_result_d = alu_result;
                    rsp_cc_d     = alu_cc;
                    rsp_err_d    = 1'b0;
`ifdef STICKY_OVF_EN
                    flags_d      = {alu_cc[3:1], flags_q[0] | alu_cc[0]};
`else
                    flags_d      = alu_cc;
`endif
                    state_d      = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef STICKY_OVF_EN
        // Clear has priority over a same-cycle capture that would set V.
        if (ovf_clr) begin
            flags_d[0] = 1'b0;
        end
`endif
    end

`ifndef STICKY_OVF_EN
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
`endif

    // Handshake and ALU drive; the ALU only sees the latched command while in EXEC.
    always_comb begin
        req_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);
        alu_valA  = 16'h0000;
        alu_valB  = 16'h0000;
        alu_aluop = 4'b0000;
        alu_sub   = 1'b0;
        if (state_q == StExec) begin
            alu_valA  = a_q;
            alu_valB  = b_q;
            alu_aluop = op_q;
            alu_sub   = (op_q == OpSub);
        end
    end

    assign rsp_result = rsp_result_q;
    assign rsp_cc     = rsp_cc_q;
    assign rsp_err    = rsp_err_q;

    // Branch condition evaluated on the architectural flags {N,Z,C,V}.
    always_comb begin
        cond_true = 1'b0;
        unique case (cond_sel)
            3'd0: cond_true = 1'b1;
            3'd1: cond_true = flags_q[2];
            3'd2: cond_true = ~flags_q[2];
            3'd3: cond_true = flags_q[3] ^ flags_q[0];
            3'd4: cond_true = ~(flags_q[3] ^ flags_q[0]);
            3'd5: cond_true = flags_q[1];
            3'd6: cond_true = flags_q[0];
            3'd7: cond_true = flags_q[3];
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: a behavioural ALU answers the DUT's ALU port,
// and a reference model predicts responses, latency and flags from the request alone.
module tb_alu_cmd_sequencer;

    localparam int unsigned BaseLat = 1;
    localparam int unsigned MulLat  = 3;

    logic        clk;
    logic        reset;
    logic        req_valid, req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_a, req_b;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_cc;
    logic        rsp_err;
    logic [15:0] alu_valA, alu_valB;
    logic [3:0]  alu_aluop;
    logic        alu_sub;
    logic [15:0] alu_result;
    logic [3:0]  alu_cc;
    logic [3:0]  flags_q;
    logic [2:0]  cond_sel;
    logic        cond_true;
    logic        ovf_clr;

    int          n_total;
    int          n_pass;
    logic [3:0]  m_flags;
    logic [15:0] last_result;
    logic [3:0]  last_cc;
    logic        last_err;

    alu_cmd_sequencer #(
        .BASE_LAT (BaseLat),
        .MUL_LAT  (MulLat)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_cc     (rsp_cc),
        .rsp_err    (rsp_err),
        .alu_valA   (alu_valA),
        .alu_valB   (alu_valB),
        .alu_aluop  (alu_aluop),
        .alu_sub    (alu_sub),
        .alu_result (alu_result),
        .alu_cc     (alu_cc),
        .flags_q    (flags_q),
        .cond_sel   (cond_sel),
        .cond_true  (cond_true),
        .ovf_clr    (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 16-bit ALU: returns {N,Z,C,V,result}; C is borrow for subtraction.
    function automatic logic [19:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic sub);
        logic [16:0] s;
        logic [15:0] r;
        logic [31:0] w;
        logic        c;
        logic        v;
        s = 17'h0;
        r = 16'h0;
        w = 32'h0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'b0001, 4'b0010: begin
                if (sub) begin
                    s = {1'b0, a} - {1'b0, b};
                    v = (a[15] != b[15]) && (s[15] != a[15]);
                end else begin
                    s = {1'b0, a} + {1'b0, b};
                    v = (a[15] == b[15]) && (s[15] != a[15]);
                end
                r = s[15:0];
                c = s[16];
            end
            4'b0101: r = a << b[3:0];
            4'b0110: r = $signed(a) >>> b[3:0];
            4'b0111: r = a >> b[3:0];
            4'b1000: begin
                w = {a, a} << b[3:0];
                r = w[31:16];
            end
            4'b1001: begin
                w = {a, a} >> b[3:0];
                r = w[15:0];
            end
            4'b1011: r = a & b;
            4'b1100: r = a | b;
            4'b1101: r = a ^ b;
            4'b1110: r = ~a;
            4'b1111: begin
                w = 32'(a) * 32'(b);
                r = w[15:0];
            end
            default: return 20'h0;
        endcase
        return {r[15], (r == 16'h0), c, v, r};
    endfunction

    assign {alu_cc, alu_result} = alu_fn(alu_aluop, alu_valA, alu_valB, alu_sub);

    function automatic logic is_legal(input logic [3:0] op);
        return !(op == 4'b0000 || op == 4'b0011 || op == 4'b0100 || op == 4'b1010);
    endfunction

    function automatic logic cond_ref(input logic [3:0] f, input logic [2:0] sel);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (sel)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return n != v;
            3'd4: return n == v;
            3'd5: return c;
            3'd6: return v;
            default: return n;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_flags_and_conds();
        check("flags_q", 32'(flags_q), 32'(m_flags));
        for (int i = 0; i < 8; i++) begin
            cond_sel = 3'(i);
            #1;
            check($sformatf("cond_true[%0d]", i), 32'(cond_true), 32'(cond_ref(m_flags, 3'(i))));
        end
    endtask

    // Issue one command, follow it to its response, hold the response for 'hold' cycles.
    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input int hold);
        logic [19:0] exp;
        logic        legal;
        int          n;
        bit          got;
        int unsigned lat;

        legal = is_legal(op);
        lat   = (op == 4'b1111) ? MulLat : BaseLat;
        exp   = legal ? alu_fn(op, a, b, op == 4'b0010) : 20'h0;

        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_before_accept", 32'(req_ready), 32'd1);

        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;

        n   = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            if (rsp_valid) begin
                got = 1'b1;
                rsp_ready = 1'b0;
            end else begin
                check("req_ready_busy", 32'(req_ready), 32'd0);
                check("alu_aluop_exec", 32'(alu_aluop), legal ? 32'(op) : 32'd0);
                check("alu_sub_exec", 32'(alu_sub), 32'(legal && op == 4'b0010));
                check("alu_valA_exec", 32'(alu_valA), legal ? 32'(a) : 32'd0);
                check("alu_valB_exec", 32'(alu_valB), legal ? 32'(b) : 32'd0);
                // Busy: command and response-ready lines must be ignored.
                req_valid = 1'($urandom);
                req_op    = 4'($urandom);
                req_a     = 16'($urandom);
                req_b     = 16'($urandom);
                rsp_ready = 1'($urandom);
            end
        end
        check("rsp_arrived", 32'(got), 32'd1);
        if (legal) begin
            check("latency_edges", 32'(n - 1), 32'(lat));
        end
        check("rsp_result", 32'(rsp_result), 32'(exp[15:0]));
        check("rsp_cc", 32'(rsp_cc), 32'(exp[19:16]));
        check("rsp_err", 32'(rsp_err), 32'(!legal));
        check("alu_aluop_resp", 32'(alu_aluop), 32'd0);
        last_result = rsp_result;
        last_cc     = rsp_cc;
        last_err    = rsp_err;

        if (legal) begin
`ifdef STICKY_OVF_EN
            m_flags = {exp[19:17], m_flags[0] | exp[16]};
`else
            m_flags = exp[19:16];
`endif
        end
        check_flags_and_conds();

        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_op    = 4'($urandom);
            @(negedge clk);
            check("rsp_valid_hold", 32'(rsp_valid), 32'd1);
            check("rsp_result_hold", 32'(rsp_result), 32'(exp[15:0]));
            check("rsp_cc_hold", 32'(rsp_cc), 32'(exp[19:16]));
            check("req_ready_hold", 32'(req_ready), 32'd0);
        end

        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
        check("req_ready_after_hs", 32'(req_ready), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        m_flags   = 4'b0000;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 4'b0000;
        req_a     = 16'h0;
        req_b     = 16'h0;
        rsp_ready = 1'b0;
        cond_sel  = 3'd0;
        ovf_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_rsp_result", 32'(rsp_result), 32'd0);
        check("reset_rsp_cc", 32'(rsp_cc), 32'd0);
        check("reset_flags", 32'(flags_q), 32'd0);
        check("reset_alu_ops", 32'({alu_valA, alu_aluop, alu_sub}), 32'd0);
        check("reset_alu_valB", 32'(alu_valB), 32'd0);
        @(negedge clk);

        // Directed cases
        run_op(4'b0001, 16'h7FFF, 16'h0001, 0);
        check("t1_result", 32'(last_result), 32'h8000);
        check("t1_cc", 32'(last_cc), 32'b1001);
        run_op(4'b0010, 16'h0005, 16'h0005, 0);
        check("t2_cc", 32'(last_cc), 32'b0100);
        run_op(4'b1111, 16'h0003, 16'h0004, 0);
        check("t3_result", 32'(last_result), 32'h000C);
        run_op(4'b0000, 16'h1234, 16'h5678, 0);
        check("t4_err", 32'(last_err), 32'd1);
        run_op(4'b0001, 16'h1111, 16'h2222, 5);

        // Reset in the middle of a MUL after making the flags nonzero
        run_op(4'b0010, 16'h0000, 16'h0001, 0);
        req_valid = 1'b1;
        req_op    = 4'b1111;
        req_a     = 16'h0007;
        req_b     = 16'h0009;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        m_flags = 4'b0000;
        check("midexec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midexec_flags", 32'(flags_q), 32'd0);
        check("midexec_req_ready", 32'(req_ready), 32'd1);
        check("midexec_aluop", 32'(alu_aluop), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midexec_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Overflow then a flag-clean op, then an ovf_clr pulse
        run_op(4'b0001, 16'h7FFF, 16'h0001, 0);
        run_op(4'b1011, 16'h0000, 16'h0000, 1);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
`ifdef STICKY_OVF_EN
        m_flags[0] = 1'b0;
`endif
        check_flags_and_conds();
        @(negedge clk);

        // Randomized traffic
        for (int k = 0; k < 80; k++) begin
            logic [3:0]  op;
            logic [15:0] a;
            logic [15:0] b;
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
            run_op(op, a, b, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
